fir_mac_sequencer: RTL and testbench
====================================

# fir_mac_sequencer

Time-multiplexed FIR engine controller. It owns a TAPS-deep sample delay line and a writable coefficient bank, and schedules one shared signed multiply-accumulate across all taps for each accepted input sample. It sits between the sample source and the filter output stage, with valid/ready handshakes on both sides. It is the sequencing alternative to a fully parallel pipelined tap array.

## Interface
- WIDTH, 32, sample and coefficient width, signed two's complement
- TAPS, 8, number of filter taps, ≥2
- ACC_WIDTH, 67, accumulator and output width; default is 2*WIDTH+clog2(TAPS)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer can accept a sample
- in_sample  in  WIDTH  signed input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  coefficient index
- coef_data  in  WIDTH  signed coefficient value
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  ACC_WIDTH  signed filter output
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, MAC, OUT.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: shift the delay line (x[0]←in_sample, x[k]←x[k-1], old x[TAPS-1] dropped), clear acc, k←0, go to MAC.
- **MAC**
  - Each cycle: acc ← acc + sext(x[k]*c[k]), then k←k+1.
  - On the cycle with k=TAPS-1: go to OUT.
- **OUT**
  - out_valid=1 and out_data=acc.
  - On out_ready: go to IDLE.
- in_ready=0 in MAC and OUT. Samples offered there are not taken; the source holds them.
- **Arithmetic:**
  - Products are full 2*WIDTH signed, sign-extended to ACC_WIDTH.
  - acc wraps modulo 2^ACC_WIDTH. It cannot overflow at default widths.
- **Coefficient writes:**
  - Accepted only in IDLE with coef_addr<TAPS: c[coef_addr]←coef_data at that edge.
  - Writes in MAC or OUT, or with an out-of-range address, are silently ignored.
- **Simultaneous coef_we and sample acceptance in IDLE:** both take effect at the same edge. The following MAC pass uses the new coefficient.
- **Reset:** asynchronous. State←IDLE, acc, k, delay line and coefficients ←0.
  - Reset during MAC or OUT discards the partial or pending result; no out_valid follows.
- **Output reset values:** in_ready=1 (IDLE), out_valid=0, out_data=0, busy=0.

## Timing
- Accept edge E0. MAC updates occur at edges E1..E_TAPS. out_valid rises after E_TAPS: TAPS cycles of latency from acceptance.
- out_data and out_valid are registered. They hold stable while out_valid&&!out_ready.
- Minimum sample period: TAPS+2 cycles (1 IDLE, TAPS MAC, 1 OUT with out_ready=1).
- in_ready returns high in the cycle after the out_valid&&out_ready edge.
- No combinational path from in_valid/out_ready to in_ready/out_valid; all handshake outputs decode from registered state.

## Structure
- Shared package fir_pkg holds:
  - state encoding localparams: IDLE=2'd0, MAC=2'd1, OUT=2'd2
  - the tap-index width function (clog2)
  - the default ACC_WIDTH formula
- Sub-module fir_coef_bank: TAPS×WIDTH register file with one synchronous write port and one asynchronous read port indexed by k, reset to zero.
- The delay line, FSM, tap counter and accumulator stay in fir_mac_sequencer.

## Test plan
All scenarios use defaults (WIDTH=32, TAPS=8).
- **Impulse:** write c[k]=k+1; feed 1, then seven 0s → outputs 1,2,3,4,5,6,7,8. A ninth sample 0 → output 0.
- **Latency/throughput:** out_ready held 1, in_valid held 1 → out_valid asserts exactly 8 cycles after each accept edge; in_ready pulses once every 10 cycles.
- **Backpressure:** hold out_ready=0 for 5 cycles in OUT → out_data constant, in_ready=0 throughout. Release → IDLE on the next cycle.
- **Signed/extreme:** all c=-2^31, feed eight samples of -2^31 → final output 2^65, with no wrap in 67 bits. c[0]=-3 (others 0), sample -5 → 15.
- **Ignored writes:** coef_we during MAC (c[0]←100) leaves c[0] unchanged in the next result. coef_addr out of range has no effect.
- **Reset mid-MAC:** assert rst at k=4 → out_valid stays 0, in_ready=1 after release, coefficients read 0, next output 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR MAC sequencer.
// Holds the state encoding, tap-index width and default accumulator width.
package fir_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        MAC  = ST_MAC,
        OUT  = ST_OUT
    } state_e;

    // Index width for a bank of 'taps' entries; never narrower than one bit.
    function automatic int tap_idx_w(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    // Full-precision accumulator: product width plus growth over all taps.
    function automatic int acc_width_default(input int width, input int taps);
        return 2 * width + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file: one synchronous write port, one asynchronous
// read port, all entries cleared by reset.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAPS  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [tap_idx_w(TAPS)-1:0]    waddr,
    input  logic signed [WIDTH-1:0]       wdata,
    input  logic [tap_idx_w(TAPS)-1:0]    raddr,
    output logic signed [WIDTH-1:0]       rdata
);

    logic signed [WIDTH-1:0] mem_q [TAPS];
    logic signed [WIDTH-1:0] mem_d [TAPS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR engine controller: one shared signed multiply-accumulate stepped across
// all taps per accepted sample, with valid/ready handshakes on both sides.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int TAPS      = 8,
    parameter int ACC_WIDTH = acc_width_default(WIDTH, TAPS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [WIDTH-1:0]       in_sample,
    input  logic                          coef_we,
    input  logic [tap_idx_w(TAPS)-1:0]    coef_addr,
    input  logic signed [WIDTH-1:0]       coef_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [ACC_WIDTH-1:0]   out_data,
    output logic                          busy
);

    localparam int               IDX_W  = tap_idx_w(TAPS);
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(TAPS - 1);

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              k_q, k_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [WIDTH-1:0]       x_q [TAPS];
    logic signed [WIDTH-1:0]       x_d [TAPS];

    logic signed [WIDTH-1:0]       coef_rd;
    logic signed [2*WIDTH-1:0]     prod;
    logic                          coef_wr_en;

    // Coefficients are only writable while no pass is in flight.
    assign coef_wr_en = coef_we && (state_q == IDLE) && (32'(coef_addr) < TAPS);

    fir_coef_bank #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_coef_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (coef_wr_en),
        .waddr (coef_addr),
        .wdata (coef_data),
        .raddr (k_q),
        .rdata (coef_rd)
    );

    assign prod = x_q[k_q] * coef_rd;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        x_d     = x_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d[0] = in_sample;
                    for (int i = 1; i < TAPS; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                // Sign-extended product; the sum wraps modulo 2^ACC_WIDTH.
                acc_d = acc_q + ACC_WIDTH'(prod);
                if (k_q == LAST_K) begin
                    k_d     = '0;
                    state_d = OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
        end
    end

    // Handshake outputs decode only from registered state.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_data  = acc_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: a transaction-level model of
// the filter checked every cycle, plus directed scenarios with literal results.
module tb_fir_mac_sequencer;

    localparam int W  = 32;
    localparam int T  = 8;
    localparam int AW = 67;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic signed [W-1:0]   in_sample = '0;
    logic                  coef_we = 1'b0;
    logic [2:0]            coef_addr = '0;
    logic signed [W-1:0]   coef_data = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic signed [AW-1:0]  out_data;
    logic                  busy;

    fir_mac_sequencer #(.WIDTH(W), .TAPS(T), .ACC_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [AW-1:0] act,
                                  input logic [AW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Transaction-level model: filter contents plus one outstanding result.
    logic signed [W-1:0]  mx [T];
    logic signed [W-1:0]  mc [T];
    logic signed [AW-1:0] exp_out;
    bit                   pending;
    int                   age;

    function automatic logic signed [AW-1:0] model_sum();
        logic signed [AW-1:0] s, a, b;
        s = '0;
        for (int i = 0; i < T; i++) begin
            a = mx[i];
            b = mc[i];
            s = s + a * b;
        end
        return s;
    endfunction

    always @(negedge clk) begin
        bit exp_valid;
        bit idle;
        if (rst) begin
            for (int i = 0; i < T; i++) begin
                mx[i] = '0;
                mc[i] = '0;
            end
            pending = 0;
            age     = 0;
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_busy", busy, 0);
        end else begin
            if (pending && age < 1000) age++;
            exp_valid = pending && (age >= T);
            check("in_ready", in_ready, !pending);
            check("busy", busy, pending);
            check("out_valid", out_valid, exp_valid);
            if (exp_valid) check("out_data", out_data, exp_out);
            idle = !pending;
            if (exp_valid && out_ready) pending = 0;
            if (coef_we && idle && int'(coef_addr) < T) mc[coef_addr] = coef_data;
            if (in_valid && idle) begin
                for (int i = T - 1; i > 0; i--) mx[i] = mx[i-1];
                mx[0]   = in_sample;
                exp_out = model_sum();
                pending = 1;
                age     = -1;
            end
        end
    end

    logic signed [AW-1:0] last_out;

    task automatic send(input logic signed [W-1:0] s);
        bit ok = 0;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_sample = s;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic get_result();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin last_out = out_data; ok = 1; break; end
        end
        if (!ok) check("result_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic run(input logic signed [W-1:0] s);
        send(s);
        get_result();
    endtask

    task automatic write_coef(input int addr, input logic signed [W-1:0] d);
        @(posedge clk); #1;
        coef_we   = 1'b1;
        coef_addr = 3'(addr);
        coef_data = d;
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    initial begin
        int rdy_cyc [$];
        int cyc;
        logic signed [AW-1:0] hold;
        bit seen;
        logic signed [AW-1:0] lit;

        repeat (3) @(negedge clk);
        check("init_in_ready", in_ready, 1);
        check("init_out_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Impulse response reproduces the coefficients.
        for (int k = 0; k < T; k++) write_coef(k, W'(k + 1));
        run(1);
        check("impulse_0", last_out, 1);
        for (int k = 1; k < T; k++) begin
            run(0);
            check("impulse_k", last_out, AW'(k + 1));
        end
        run(0);
        check("impulse_flushed", last_out, 0);

        // Streaming with in_valid and out_ready held high.
        cyc = 0;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_sample = $urandom;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            seen = in_ready;
            if (seen) rdy_cyc.push_back(cyc);
            cyc++;
            @(posedge clk); #1;
            if (seen) in_sample = $urandom;
        end
        in_valid = 1'b0;
        check("stream_accepts", (rdy_cyc.size() >= 4), 1);
        for (int i = 1; i < rdy_cyc.size(); i++)
            check("stream_period", AW'(rdy_cyc[i] - rdy_cyc[i-1]), 10);
        repeat (12) @(posedge clk);
        #1;

        // Backpressure holds the result and blocks input.
        out_ready = 1'b0;
        send(W'(-7));
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1; break; end
        end
        check("bp_valid_seen", seen, 1);
        hold = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_data", out_data, hold);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_after", in_ready, 1);
        @(posedge clk); #1;

        // Signed extremes.
        for (int k = 0; k < T; k++) write_coef(k, 32'sh8000_0000);
        for (int k = 0; k < T; k++) run(32'sh8000_0000);
        lit = 67'sh2_0000_0000_0000_0000;
        check("extreme_2p65", last_out, lit);
        write_coef(0, -3);
        for (int k = 1; k < T; k++) write_coef(k, 0);
        run(-5);
        check("neg_times_neg", last_out, 15);

        // Write during a MAC pass is ignored.
        write_coef(0, 7);
        send(2);
        @(posedge clk); #1;
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 100;
        @(posedge clk); #1;
        coef_we = 1'b0;
        get_result();
        check("ignored_write_a", last_out, 14);
        run(1);
        check("ignored_write_b", last_out, 7);

        // Reset in the middle of a pass.
        send(5);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("rst_mid_no_valid", out_valid, 0);
            check("rst_mid_ready", in_ready, 1);
        end
        run(9);
        check("rst_mid_next_zero", last_out, 0);

        // Randomized traffic, coefficient writes and stalls.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: in_sample = 32'sh8000_0000;
                1: in_sample = 32'sh7fff_ffff;
                default: in_sample = $urandom;
            endcase
            coef_we   = ($urandom_range(0, 3) == 0);
            coef_addr = 3'($urandom);
            coef_data = ($urandom_range(0, 4) == 0) ? 32'sh8000_0000 : $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        coef_we = 1'b0;
        out_ready = 1'b1;
        repeat (15) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
